uart_tx_core: RTL and testbench
===============================

# uart_tx_core

UART transmit engine for the low-latency UART IP core: the transmit-direction counterpart of the oversampling receive baud generator. It accepts a parallel word over a valid/ready handshake and serialises it as start bit, data (LSB first), optional parity and stop bit(s). Bit timing comes from an integrated 1x baud divider that is restarted on every accepted word, so the start bit begins on the cycle after acceptance. It sits between the host/FIFO side and the `tx` pad.

## Interface
- `SYS_CLK_FREQ`, 50_000_000, system clock frequency in Hz
- `BAUD_RATE`, 9600, line rate in bit/s
- `DATA_BITS`, 8, data bits per frame, legal range 5..9
- `STOP_BITS`, 1, stop bits per frame, 1 or 2
- `PARITY_ODD`, 0, 0 = even parity, 1 = odd parity; used only with `UART_TX_PARITY_EN`

- `clock`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `tx_data`  in  DATA_BITS  word to send; sampled only on acceptance
- `tx_valid`  in  1  `tx_data` is valid
- `tx_ready`  out  1  core can accept a word
- `tx`  out  1  serial line, idle high
- `tx_busy`  out  1  frame in progress
- `bit_tick`  out  1  one-cycle pulse at the end of each bit period

## Operation
- DIVISOR = (SYS_CLK_FREQ + BAUD_RATE/2) / BAUD_RATE, rounded to nearest. Elaboration error if DIVISOR < 2. Counter width = $clog2(DIVISOR).
- States: IDLE, START, DATA, PARITY (only with the macro), STOP.
- IDLE: `tx`=1, `tx_ready`=1, `tx_busy`=0, baud counter held at 0.
- Acceptance happens when `tx_valid && tx_ready` at a rising edge. `tx_data` is loaded into the shift register, the baud counter is cleared, and the state moves to START.
- Counter counts 0..DIVISOR-1. `bit_tick` is high when the count is DIVISOR-1; on that cycle the count wraps to 0 and the FSM advances.
- START → DATA after 1 tick.
- DATA shifts right on each tick. The bit index runs 0..DATA_BITS-1. After the last bit the FSM goes to PARITY, or to STOP when parity is compiled out.
- PARITY → STOP after 1 tick.
- STOP → IDLE after STOP_BITS ticks.
- `tx_ready` = (state == IDLE), combinational from the state register. `tx_valid` outside IDLE is ignored; there is no queueing.
- Changes on `tx_data` after acceptance have no effect on the frame.
- `tx` is registered (glitch-free) and driven from the state/shift register.
- Reset at any point, including mid-frame: asynchronously force IDLE, `tx`=1, `tx_ready`=1, `tx_busy`=0, `bit_tick`=0, counter=0, shift register=0. The aborted frame is not resumed.

## Timing
- Reset values: `tx`=1, `tx_ready`=1, `tx_busy`=0, `bit_tick`=0.
- Acceptance at edge N: `tx`=0 and `tx_busy`=1 from edge N+1. Start bit lasts exactly DIVISOR cycles.
- Every bit lasts exactly DIVISOR cycles. Frame length F = (1 + DATA_BITS + P + STOP_BITS) × DIVISOR, where P = 1 with parity, else 0.
- `tx_ready` returns at edge N+1+F. Minimum spacing between back-to-back acceptances is F+1 cycles, i.e. one idle cycle with `tx`=1.
- `bit_tick` is not asserted in IDLE.

## Configuration
- `UART_TX_PARITY_EN` defined: a PARITY state follows the data bits.
  - Parity bit = ^data for even parity, ~^data for odd parity, selected by `PARITY_ODD`.
  - Parity is computed from the shift register at load time and held in a flop.
- Not defined: no PARITY state and no parity flop; `PARITY_ODD` is ignored; DATA goes straight to STOP.

## Structure
- Package `uart_pkg`:
  - `tx_state_t` enum.
  - `calc_divisor(clk, baud)` function.
  - Parity-mode localparams, shared with the RX side.
- Sub-module `uart_tx_baud_div`:
  - Inputs: `clock`, `reset`, `restart`, `enable`.
  - Output: `bit_tick`.
  - Parameter: DIVISOR.
  - Natural split because it mirrors the RX baud generator.
- Remaining logic (FSM, shift register, bit/stop counters) stays in `uart_tx_core`.

## Test plan
Bench parameters: SYS_CLK_FREQ=1_000_000, BAUD_RATE=100_000 (DIVISOR=10), DATA_BITS=8.
- Reset check: assert `reset`, then release → `tx`=1, `tx_ready`=1, `tx_busy`=0, no `bit_tick` for 50 cycles.
- Single frame, no parity: send 0x55 → `tx` samples mid-bit read 0,1,0,1,0,1,0,1,0,1. Each level lasts 10 cycles. `tx_ready` returns 100 cycles after acceptance.
- Parity frame, macro defined, `PARITY_ODD`=0: send 0xA7 → data bits 1,1,1,0,0,1,0,1, then parity 1, then stop 1. Frame is 110 cycles.
- Back-to-back with `tx_valid` held high: send 0x00 then 0xFF → second start bit begins exactly 1 idle cycle after the first frame's stop bit. `tx_data` changed mid-frame does not alter the first frame.
- `STOP_BITS`=2: send 0x0F → stop high for 20 cycles. `tx_ready` returns at 110 cycles.
- Reset mid-frame: assert `reset` during data bit 3 → `tx`=1 immediately (asynchronous). After release, `tx_ready`=1 and a new 0x3C frame is sent correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: TX state encoding, baud divisor helper and parity modes.
// The TX PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_pkg;

  localparam int unsigned PAR_EVEN = 0;
  localparam int unsigned PAR_ODD  = 1;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
`ifdef UART_TX_PARITY_EN
    TX_PARITY,
`endif
    TX_STOP
  } tx_state_t;

  // Divisor rounded to the nearest integer clock count per bit.
  function automatic int unsigned calc_divisor(input int unsigned clk, input int unsigned baud);
    return (clk + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_tx_baud_div.sv
// 1x baud divider for the TX engine; counts 0..DIVISOR-1 while enabled and
// pulses bit_tick on the last count. Restart or disable holds the count at 0.
module uart_tx_baud_div #(
  parameter int unsigned DIVISOR = 10
) (
  input  logic clock,
  input  logic reset,
  input  logic restart,
  input  logic enable,
  output logic bit_tick
);

  localparam int unsigned CW = (DIVISOR < 2) ? 1 : $clog2(DIVISOR);

  if (DIVISOR < 2) begin : g_bad_divisor
    $error("uart_tx_baud_div: DIVISOR must be at least 2");
  end

  logic [CW-1:0] count;

  assign bit_tick = enable && (count == CW'(DIVISOR - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (restart || !enable) begin
      count <= '0;
    end else if (bit_tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_core.sv
// UART transmit engine: start bit, DATA_BITS LSB first, optional parity, STOP_BITS stop bits.
// Define UART_TX_PARITY_EN to add a parity bit (even/odd per PARITY_ODD).
module uart_tx_core
  import uart_pkg::*;
#(
  parameter int unsigned SYS_CLK_FREQ = 50_000_000,
  parameter int unsigned BAUD_RATE    = 9600,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned PARITY_ODD   = 0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 bit_tick
);

  localparam int unsigned DIVISOR = calc_divisor(SYS_CLK_FREQ, BAUD_RATE);
  localparam int unsigned IDX_W   = $clog2(DATA_BITS);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_core: DATA_BITS must be 5..9");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_core: STOP_BITS must be 1 or 2");
  end
  if (PARITY_ODD != PAR_EVEN && PARITY_ODD != PAR_ODD) begin : g_bad_parity
    $error("uart_tx_core: PARITY_ODD must be 0 or 1");
  end

  tx_state_t            state, state_next;
  logic [DATA_BITS-1:0] shift_q, shift_next;
  logic [IDX_W-1:0]     idx_q, idx_next;
  logic                 stop_q, stop_next;
  logic                 tx_next;
  logic                 accept;
`ifdef UART_TX_PARITY_EN
  logic                 par_q, par_next;
`endif

  assign tx_ready = (state == TX_IDLE);
  assign tx_busy  = (state != TX_IDLE);
  assign accept   = tx_valid && tx_ready;

  uart_tx_baud_div #(
    .DIVISOR(DIVISOR)
  ) u_baud_div (
    .clock   (clock),
    .reset   (reset),
    .restart (accept),
    .enable  (tx_busy),
    .bit_tick(bit_tick)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= TX_IDLE;
      tx      <= 1'b1;
      shift_q <= '0;
      idx_q   <= '0;
      stop_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state   <= state_next;
      tx      <= tx_next;
      shift_q <= shift_next;
      idx_q   <= idx_next;
      stop_q  <= stop_next;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_next;
`endif
    end
  end

  // tx is precomputed here so the line level flips on the same edge as the state.
  always_comb begin
    state_next = state;
    tx_next    = tx;
    shift_next = shift_q;
    idx_next   = idx_q;
    stop_next  = stop_q;
`ifdef UART_TX_PARITY_EN
    par_next   = par_q;
`endif
    case (state)
      TX_IDLE: begin
        tx_next = 1'b1;
        if (accept) begin
          state_next = TX_START;
          tx_next    = 1'b0;
          shift_next = tx_data;
          idx_next   = '0;
          stop_next  = 1'b0;
`ifdef UART_TX_PARITY_EN
          par_next   = (PARITY_ODD == PAR_ODD) ? ~^tx_data : ^tx_data;
`endif
        end
      end
      TX_START: begin
        if (bit_tick) begin
          state_next = TX_DATA;
          tx_next    = shift_q[0];
        end
      end
      TX_DATA: begin
        if (bit_tick) begin
          shift_next = shift_q >> 1;
          if (idx_q == IDX_W'(DATA_BITS - 1)) begin
            stop_next = 1'b0;
`ifdef UART_TX_PARITY_EN
            state_next = TX_PARITY;
            tx_next    = par_q;
`else
            state_next = TX_STOP;
            tx_next    = 1'b1;
`endif
          end else begin
            idx_next = idx_q + 1'b1;
            tx_next  = shift_next[0];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      TX_PARITY: begin
        if (bit_tick) begin
          state_next = TX_STOP;
          tx_next    = 1'b1;
        end
      end
`endif
      TX_STOP: begin
        tx_next = 1'b1;
        if (bit_tick) begin
          if (stop_q == 1'(STOP_BITS - 1)) begin
            state_next = TX_IDLE;
          end else begin
            stop_next = stop_q + 1'b1;
          end
        end
      end
      default: begin
        state_next = TX_IDLE;
        tx_next    = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_core.sv
// Scoreboard bench for uart_tx_core: one instance with one stop bit, one with two.
module tb_uart_tx_core;

  localparam int DIV = 10;
`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       sel;
  logic       valid1, valid2;
  logic       ready1, tx1, busy1, tick1;
  logic       ready2, tx2, busy2, tick2;
  logic       obs_ready, obs_tx, obs_busy, obs_tick;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic        exp_q[$];

  always #5 clk = ~clk;

  assign valid1    = tx_valid && !sel;
  assign valid2    = tx_valid && sel;
  assign obs_ready = sel ? ready2 : ready1;
  assign obs_tx    = sel ? tx2 : tx1;
  assign obs_busy  = sel ? busy2 : busy1;
  assign obs_tick  = sel ? tick2 : tick1;

  uart_tx_core #(
    .SYS_CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)
  ) u_dut1 (
    .clock(clk), .reset(rst), .tx_data(tx_data), .tx_valid(valid1),
    .tx_ready(ready1), .tx(tx1), .tx_busy(busy1), .bit_tick(tick1)
  );

  uart_tx_core #(
    .SYS_CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8), .STOP_BITS(2), .PARITY_ODD(0)
  ) u_dut2 (
    .clock(clk), .reset(rst), .tx_data(tx_data), .tx_valid(valid2),
    .tx_ready(ready2), .tx(tx2), .tx_busy(busy2), .bit_tick(tick2)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic push_frame(input logic [7:0] d, input int stops);
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
    if (PAR == 1) exp_q.push_back(^d);
    for (int i = 0; i < stops; i++) exp_q.push_back(1'b1);
  endtask

  task automatic start_frame(input logic [7:0] d, input int stops);
    int w = 0;
    @(negedge clk);
    while (!obs_ready && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (!obs_ready) check_eq("ready_wait", 32'(obs_ready), 1);
    tx_data  = d;
    tx_valid = 1'b1;
    @(posedge clk);
    push_frame(d, stops);
  endtask

  // Called right after the acceptance edge; c counts negedges after it.
  task automatic check_frame(input int stops, input bit hold, input bit chg, input logic [7:0] new_data);
    int   f = (1 + 8 + PAR + stops) * DIV;
    int   ticks = 0;
    logic exp_bit = 1'b1;
    for (int c = 0; c <= f; c++) begin
      @(negedge clk);
      if (c == 0 && !hold) tx_valid = 1'b0;
      if (chg && c == 30) tx_data = new_data;
      if (c < f) begin
        if (c % DIV == 0) begin
          if (exp_q.size() == 0) check_eq("sb_empty", 32'(exp_q.size()), 1);
          else exp_bit = exp_q.pop_front();
          check_eq("busy", 32'(obs_busy), 1);
          check_eq("ready_low", 32'(obs_ready), 0);
        end
        if (c % DIV == 0 || c % DIV == DIV - 1) check_eq("tx_bit", 32'(obs_tx), 32'(exp_bit));
        check_eq("bit_tick", 32'(obs_tick), 32'(c % DIV == DIV - 1));
        if (obs_tick) ticks++;
        if (c == f - 1) check_eq("ready_early", 32'(obs_ready), 0);
      end else begin
        check_eq("ready_ret", 32'(obs_ready), 1);
        check_eq("idle_tx", 32'(obs_tx), 1);
        check_eq("busy_clr", 32'(obs_busy), 0);
        check_eq("idle_tick", 32'(obs_tick), 0);
        check_eq("tick_count", 32'(ticks), 32'(f / DIV));
        check_eq("sb_drained", 32'(exp_q.size()), 0);
      end
    end
  endtask

  initial begin
    rst      = 1'b1;
    tx_valid = 1'b0;
    tx_data  = '0;
    sel      = 1'b0;
    #1;
    check_eq("rst_tx", 32'(tx1), 1);
    check_eq("rst_ready", 32'(ready1), 1);
    check_eq("rst_busy", 32'(busy1), 0);
    check_eq("rst_tick", 32'(tick1), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check_eq("idle_no_tick", 32'({tick1, tick2}), 0);
    end
    check_eq("idle_tx1", 32'(tx1), 1);
    check_eq("idle_ready1", 32'(ready1), 1);
    check_eq("idle_busy1", 32'(busy1), 0);
    check_eq("idle_ready2", 32'(ready2), 1);

    start_frame(8'h55, 1);
    check_frame(1, 1'b0, 1'b0, 8'h00);

    start_frame(8'hA7, 1);
    check_frame(1, 1'b0, 1'b0, 8'h00);

    // back-to-back with valid held; data changes mid-frame
    start_frame(8'h00, 1);
    check_frame(1, 1'b1, 1'b1, 8'hFF);
    @(posedge clk);
    push_frame(8'hFF, 1);
    check_frame(1, 1'b0, 1'b0, 8'h00);

    sel = 1'b1;
    start_frame(8'h0F, 2);
    check_frame(2, 1'b0, 1'b0, 8'h00);
    check_eq("dut1_idle_during_dut2", 32'(ready1), 1);

    sel = 1'b0;
    start_frame(8'hA5, 1);
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (45) @(negedge clk);
    check_eq("mid_busy", 32'(busy1), 1);
    #2 rst = 1'b1;
    #1;
    check_eq("arst_tx", 32'(tx1), 1);
    check_eq("arst_ready", 32'(ready1), 1);
    check_eq("arst_busy", 32'(busy1), 0);
    check_eq("arst_tick", 32'(tick1), 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("post_rst_ready", 32'(ready1), 1);
    check_eq("post_rst_tx", 32'(tx1), 1);
    start_frame(8'h3C, 1);
    check_frame(1, 1'b0, 1'b0, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
